// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and the
// default word/chain geometry used across the tile library.
package ccff_pkg;

  localparam int unsigned CCFF_DATA_W    = 8;
  localparam int unsigned CCFF_CHAIN_LEN = 32;
  localparam int unsigned CCFF_CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE,
    ERR
  } ccff_state_e;

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word bitstream buffer: accepts a word over valid/ready and presents it
// MSB-first, one bit per cycle, refilling in the cycle its last bit leaves.
module ccff_word_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              active_i,
  input  logic              flush_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              bit_o,
  output logic              empty_o
);

  localparam int REM_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] buf_q, buf_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              shift;

  assign empty_o = (rem_q == '0);
  assign shift   = active_i && !empty_o;
  assign bit_o   = buf_q[DATA_W-1];

  // Refill when empty or when the last bit leaves now; never on the shift that ends a pass.
  assign bs_ready = active_i && !last_i && (empty_o || rem_q == REM_W'(1));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    buf_d = buf_q;
    rem_d = rem_q;
    if (flush_i) begin
      rem_d = '0;
    end else if (bs_valid && bs_ready) begin
      buf_d = bs_data;
      rem_d = REM_W'(DATA_W);
    end else if (shift) begin
      buf_d = buf_q << 1;
      rem_d = rem_q - REM_W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  // NOTE: the data buffer is reset too; it is a single register, not a memory array, so it costs nothing.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      buf_q <= '0;
      rem_q <= '0;
    end else begin
      buf_q <= buf_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/ccff_stream_loader.sv
// Drives a tile configuration chain from a word stream, optionally re-shifting
// the same stream while comparing the returning chain tail bit-by-bit.
module ccff_stream_loader
  import ccff_pkg::*;
#(
  parameter int DATA_W    = CCFF_DATA_W,
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN,
  parameter int CNT_W     = CCFF_CNT_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_idx
);

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_idx_q, err_idx_d;
  logic             vfy_q, vfy_d;
  logic             head_q, head_d;
  logic             shift_en_q, shift_en_d;

  logic in_pass, cnt_full, start_acc, mismatch;
  logic ser_active, ser_flush, ser_bit, ser_empty, shift_now, last_shift;

  assign in_pass   = (state_q == LOAD) || (state_q == VERIFY);
  assign cnt_full  = (bit_cnt_q == LEN);
  assign start_acc = start && !in_pass;

  // ccff_head carries pass-2 bit (bit_cnt-1) whenever bit_cnt is non-zero in VERIFY;
  // the first VERIFY cycle still shows the last pass-1 bit and is skipped.
  assign mismatch = (state_q == VERIFY) && shift_en_q && (bit_cnt_q != '0) &&
                    (ccff_tail != head_q);

  assign ser_active = in_pass && !cnt_full && !mismatch;
  assign shift_now  = ser_active && !ser_empty;
  assign last_shift = shift_now && (bit_cnt_q == LAST);
  assign ser_flush  = start_acc || last_shift;

  ccff_word_serializer #(
    .DATA_W(DATA_W)
  ) u_serializer (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .active_i  (ser_active),
    .flush_i   (ser_flush),
    .last_i    (last_shift),
    .bs_data   (bs_data),
    .bs_valid  (bs_valid),
    .bs_ready  (bs_ready),
    .bit_o     (ser_bit),
    .empty_o   (ser_empty)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    err_idx_d  = err_idx_q;
    vfy_d      = vfy_q;
    head_d     = head_q;
    shift_en_d = 1'b0;

    if (shift_now) begin
      head_d     = ser_bit;
      shift_en_d = 1'b1;
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          err_idx_d = '0;
          vfy_d     = verify_en;
        end
      end
      LOAD: begin
        if (last_shift) begin
          if (vfy_q) begin
            state_d   = VERIFY;
            bit_cnt_d = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      VERIFY: begin
        // The final pass-2 bit is compared one cycle after it leaves the buffer.
        if (mismatch) begin
          state_d   = ERR;
          err_idx_d = bit_cnt_q - CNT_W'(1);
        end else if (cnt_full) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      err_idx_q  <= '0;
      vfy_q      <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      err_idx_q  <= err_idx_d;
      vfy_q      <= vfy_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign ccff_head = head_q;
  assign shift_en  = shift_en_q;
  assign busy      = in_pass;
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: a 32-bit and a 20-bit chain instance share the
// stimulus; a DFF-chain model supplies ccff_tail and the expected bit stream.
module tb_ccff_stream_loader;

  logic       prog_clk = 1'b0;
  logic       prog_reset, start, verify_en, bs_valid, sel;
  logic [7:0] bs_data;

  logic       start_a, start_b, valid_a, valid_b, tail_a, tail_b;
  logic       ready_a, head_a, se_a, busy_a, done_a, error_a;
  logic       ready_b, head_b, se_b, busy_b, done_b, error_b;
  logic [5:0] eidx_a, eidx_b;

  logic       bs_ready, ccff_head, shift_en, busy, done, error, ccff_tail;
  logic [5:0] err_idx;

  always #5 prog_clk = ~prog_clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign valid_a = bs_valid & ~sel;
  assign valid_b = bs_valid & sel;
  assign tail_a  = sel ? 1'b0 : ccff_tail;
  assign tail_b  = sel ? ccff_tail : 1'b0;

  assign bs_ready  = sel ? ready_b : ready_a;
  assign ccff_head = sel ? head_b  : head_a;
  assign shift_en  = sel ? se_b    : se_a;
  assign busy      = sel ? busy_b  : busy_a;
  assign done      = sel ? done_b  : done_a;
  assign error     = sel ? error_b : error_a;
  assign err_idx   = sel ? eidx_b  : eidx_a;

  ccff_stream_loader #(.DATA_W(8), .CHAIN_LEN(32), .CNT_W(6)) u_dut32 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a), .verify_en(verify_en),
    .bs_data(bs_data), .bs_valid(valid_a), .bs_ready(ready_a), .ccff_head(head_a),
    .shift_en(se_a), .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .error(error_a),
    .err_idx(eidx_a));

  ccff_stream_loader #(.DATA_W(8), .CHAIN_LEN(20), .CNT_W(6)) u_dut20 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b), .verify_en(verify_en),
    .bs_data(bs_data), .bs_valid(valid_b), .bs_ready(ready_b), .ccff_head(head_b),
    .shift_en(se_b), .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .error(error_b),
    .err_idx(eidx_b));

  int          n_checks = 0, n_fail = 0;
  logic [7:0]  wd [4];
  int          clen = 32, wpp = 4, total_words = 4, stuck_idx = -1;
  int          n_shift = 0, n_acc = 0, gap = 0, mis_idx = 0, idx;
  bit          vfy_m = 1'b0, mis_seen = 1'b0, mon_en = 1'b0;
  logic        last_head [2];
  logic [31:0] chain_v = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream bit k is bit (7 - k%8) of word k/8.
  function automatic logic exp_bit(input int k);
    logic [7:0] w;
    w = wd[k / 8];
    return w[7 - (k % 8)];
  endfunction

  // Chain of clen DFFs: the head enters FF clen-1, the tail is FF 0, so stream bit k rests in FF k.
  always @(posedge prog_clk) begin : chain_model
    logic [31:0] nxt;
    if (shift_en) begin
      nxt = chain_v >> 1;
      nxt[clen - 1] = ccff_head;
      if (stuck_idx >= 0) nxt[stuck_idx] = 1'b0;
      chain_v <= nxt;
    end
  end
  assign ccff_tail = chain_v[0];

  always @(posedge prog_clk) begin
    if (mon_en && bs_valid && bs_ready) n_acc++;
  end

  always @(negedge prog_clk) begin
    if (mon_en) begin
      check("done_error_exclusive", {31'd0, done & error}, 32'd0);
      if (!busy) check("ready_when_idle", {31'd0, bs_ready}, 32'd0);
      if (n_acc >= total_words) check("ready_after_last_word", {31'd0, bs_ready}, 32'd0);
      if (error) begin
        check("shift_en_in_err", {31'd0, shift_en}, 32'd0);
        check("ready_in_err", {31'd0, bs_ready}, 32'd0);
      end
      if (shift_en) begin
        idx = n_shift % clen;
        check("shift_budget", {31'd0, n_shift < (vfy_m ? 2 : 1) * clen}, 32'd1);
        check("head_bit", {31'd0, ccff_head}, {31'd0, exp_bit(idx)});
        if (vfy_m && n_shift >= clen && !mis_seen && ccff_tail !== exp_bit(idx)) begin
          mis_seen = 1'b1;
          mis_idx  = idx;
        end
        last_head[sel] = ccff_head;
        n_shift++;
      end else begin
        check("head_held", {31'd0, ccff_head}, {31'd0, last_head[sel]});
        if (busy && n_shift > 0 && n_shift < clen) gap++;
      end
    end
  end

  function automatic logic [31:0] chain_word(input int len);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < len; k++) r[len - 1 - k] = chain_v[k];
    return r;
  endfunction

  task automatic pulse_start(input bit v);
    verify_en = v;
    start     = 1'b1;
    @(negedge prog_clk);
    start     = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, output bit ok);
    bit got;
    got = 1'b0;
    bs_data  = w;
    bs_valid = 1'b1;
    for (int t = 0; t < 200 && busy && !got; t++) begin
      got = bs_ready;
      @(negedge prog_clk);
    end
    bs_valid = 1'b0;
    if (busy && !got) check("send_timeout", 32'd1, 32'd0);
    ok = got;
  endtask

  task automatic stall(input int n);
    bs_valid = 1'b0;
    for (int t = 0; t < 100 && !bs_ready; t++) @(negedge prog_clk);
    repeat (n) @(negedge prog_clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge prog_clk);
      ok = !busy;
    end
    check("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic setup(input bit s, input bit vfy, input int stuck);
    sel         = s;
    clen        = s ? 20 : 32;
    wpp         = (clen + 7) / 8;
    vfy_m       = vfy;
    total_words = (vfy ? 2 : 1) * wpp;
    stuck_idx   = stuck;
    n_shift     = 0;
    n_acc       = 0;
    gap         = 0;
    mis_seen    = 1'b0;
    mis_idx     = 0;
    mon_en      = 1'b1;
  endtask

  task automatic run_test(input bit s, input bit vfy, input int stall_before, input int stall_n,
                          input bit rnd_gap, input int stuck);
    bit          ok, exp_err;
    logic [31:0] ev, mask;
    setup(s, vfy, stuck);
    pulse_start(vfy);
    ok = 1'b1;
    for (int p = 0; p < (vfy ? 2 : 1) && ok; p++) begin
      for (int i = 0; i < wpp && ok; i++) begin
        if (p == 0 && i == stall_before) stall(stall_n);
        else if (rnd_gap) begin
          bs_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge prog_clk);
        end
        send_word(wd[i], ok);
      end
    end
    wait_idle();
    @(negedge prog_clk);
    exp_err = vfy && mis_seen;
    check("done", {31'd0, done}, {31'd0, !exp_err});
    check("error", {31'd0, error}, {31'd0, exp_err});
    check("busy_end", {31'd0, busy}, 32'd0);
    if (exp_err) begin
      check("err_idx", {26'd0, err_idx}, mis_idx);
      check("shifts_to_err", n_shift, clen + mis_idx + 1);
    end else begin
      check("shift_count", n_shift, (vfy ? 2 : 1) * clen);
      check("word_count", n_acc, total_words);
      ev = '0;
      mask = '0;
      for (int k = 0; k < clen; k++) begin
        ev[k]   = exp_bit(k);
        mask[k] = 1'b1;
      end
      check("chain_contents", chain_v & mask, ev);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit s, v;
    int st;
    last_head[0] = 1'b0;
    last_head[1] = 1'b0;
    prog_reset = 1'b1;
    start      = 1'b0;
    verify_en  = 1'b0;
    bs_valid   = 1'b0;
    bs_data    = '0;
    sel        = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_shift_en", {31'd0, shift_en}, 32'd0);
    check("rst_head", {31'd0, ccff_head}, 32'd0);
    check("rst_ready", {31'd0, bs_ready}, 32'd0);
    check("rst_err_idx", {26'd0, err_idx}, 32'd0);
    prog_reset = 1'b0;
    @(negedge prog_clk);

    // Load only, continuous valid.
    wd = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    run_test(1'b0, 1'b0, -1, 0, 1'b0, -1);
    check("t1_shifts", n_shift, 32'd32);
    check("t1_chain", chain_word(32), 32'hA53CFF01);
    check("t1_gap", gap, 32'd0);

    // Three-cycle source stall before word 3.
    run_test(1'b0, 1'b0, 2, 3, 1'b0, -1);
    check("t2_gap", gap, 32'd3);
    check("t2_chain", chain_word(32), 32'hA53CFF01);

    // Clean verify pass.
    run_test(1'b0, 1'b1, -1, 0, 1'b0, -1);
    check("t3_shifts", n_shift, 32'd64);
    check("t3_error", {31'd0, error}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd1);

    // Verify against a chain with FF 9 stuck at 0; stream bits 0..8 are 0, bit 9 is 1.
    wd = '{8'h00, 8'h40, 8'hFF, 8'h81};
    run_test(1'b0, 1'b1, -1, 0, 1'b0, 9);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_err_idx", {26'd0, err_idx}, 32'd9);
    check("t4_shift_en", {31'd0, shift_en}, 32'd0);
    check("t4_ready", {31'd0, bs_ready}, 32'd0);

    // 20-bit chain: three words, last nibble of word 3 dropped.
    wd = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    run_test(1'b1, 1'b0, -1, 0, 1'b0, -1);
    check("t5_shifts", n_shift, 32'd20);
    check("t5_words", n_acc, 32'd3);
    check("t5_chain", chain_word(20), 32'h000A53CF);

    // Reset after ten shifts, then a clean reload.
    setup(1'b0, 1'b0, -1);
    pulse_start(1'b0);
    begin
      bit ok;
      send_word(wd[0], ok);
      send_word(wd[1], ok);
    end
    for (int t = 0; t < 100 && n_shift < 10; t++) @(negedge prog_clk);
    mon_en     = 1'b0;
    prog_reset = 1'b1;
    @(negedge prog_clk);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_error", {31'd0, error}, 32'd0);
    check("t6_shift_en", {31'd0, shift_en}, 32'd0);
    check("t6_head", {31'd0, ccff_head}, 32'd0);
    check("t6_ready", {31'd0, bs_ready}, 32'd0);
    check("t6_err_idx", {26'd0, err_idx}, 32'd0);
    prog_reset   = 1'b0;
    last_head[0] = 1'b0;
    last_head[1] = 1'b0;
    @(negedge prog_clk);
    run_test(1'b0, 1'b0, -1, 0, 1'b0, -1);
    check("t6_reload_chain", chain_word(32), 32'hA53CFF01);

    // Randomised words, gaps, chain length, verify mode and stuck faults.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
      s  = 1'($urandom_range(0, 1));
      v  = 1'($urandom_range(0, 1));
      st = (v && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, s ? 19 : 31)) : -1;
      run_test(s, v, -1, 0, 1'b1, st);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
